// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmitter and the matching receiver.
package uart_pkg;

  localparam int DATA_BITS      = 8;
  localparam int FRAME_BITS_8N1 = 10;
  localparam int FRAME_BITS_8E1 = 11;
  localparam int BAUD_W         = 24;

  localparam logic [BAUD_W-1:0] DEFAULT_CLOCKS_PER_BAUD = 24'd868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// Loadable down-counter that parks at zero; load takes priority over counting.
module uart_baud_counter
  import uart_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              load,
  input  logic [BAUD_W-1:0] load_value,
  output logic [BAUD_W-1:0] count,
  output logic              zero
);

  logic [BAUD_W-1:0] count_reg;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);

endmodule

// File: rtl/uart_txser.sv
// Byte-serial UART transmitter, 8N1 by default; define UART_TX_PARITY_EN
// to insert a parity bit (sense set by PARITY_ODD) before the stop bit.
module uart_txser
  import uart_pkg::*;
#(
  parameter logic [BAUD_W-1:0] CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD,
  parameter logic              PARITY_ODD      = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_wr,
  input  logic [7:0] i_data,
  output logic       o_uart_tx,
  output logic       o_busy
);

  tx_state_t         state_reg;
  logic [7:0]        shift_reg;
  logic [2:0]        bit_idx_reg;
  logic              tx_reg;
  logic              busy_reg;
  logic              accept;
  logic              baud_load;
  logic              baud_zero;
  logic [BAUD_W-1:0] baud_count;

`ifdef UART_TX_PARITY_EN
  logic parity_reg;
`else
  logic unused_parity_sense;
  assign unused_parity_sense = PARITY_ODD;
`endif

  // busy is only low in IDLE or in the last stop-bit cycle, so a write there
  // chains straight into the next start bit.
  assign accept    = i_wr && !busy_reg;
  assign baud_load = accept ||
                     (baud_zero && (state_reg == START || state_reg == DATA ||
                                    state_reg == PARITY));

  uart_baud_counter u_baud (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .load       (baud_load),
    .load_value (CLOCKS_PER_BAUD - 1'b1),
    .count      (baud_count),
    .zero       (baud_zero)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg   <= IDLE;
      shift_reg   <= '1;
      bit_idx_reg <= '0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else if (accept) begin
      state_reg   <= START;
      shift_reg   <= i_data;
      tx_reg      <= 1'b0;
      busy_reg    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_reg  <= (^i_data) ^ PARITY_ODD;
`endif
    end else begin
      case (state_reg)
        START: begin
          if (baud_zero) begin
            state_reg   <= DATA;
            tx_reg      <= shift_reg[0];
            shift_reg   <= {1'b1, shift_reg[7:1]};
            bit_idx_reg <= '0;
          end
        end
        DATA: begin
          if (baud_zero) begin
            if (bit_idx_reg == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state_reg <= PARITY;
              tx_reg    <= parity_reg;
`else
              state_reg <= STOP;
              tx_reg    <= 1'b1;
`endif
            end else begin
              tx_reg      <= shift_reg[0];
              shift_reg   <= {1'b1, shift_reg[7:1]};
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end
        end
        PARITY: begin
          if (baud_zero) begin
            state_reg <= STOP;
            tx_reg    <= 1'b1;
          end
        end
        STOP: begin
          // Release busy one cycle early so the final stop cycle can accept.
          if (baud_count == BAUD_W'(1)) begin
            busy_reg <= 1'b0;
          end
          if (baud_zero) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign o_uart_tx = tx_reg;
  assign o_busy    = busy_reg;

endmodule

// File: tb/tb_uart_txser.sv
// Self-checking bench for uart_txser: a timeline model of the frame is compared
// every cycle, plus directed frames checked against hand-written bit patterns.
module tb_uart_txser;

  localparam int   N          = 4;
  localparam logic PARITY_ODD = 1'b0;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
  localparam logic [10:0] L55 = 11'h4AA, LA5 = 11'h54A, LFF = 11'h5FE,
                          L3C = 11'h478, L07 = 11'h60E;
`else
  localparam int FB = 10;
  localparam logic [10:0] L55 = 11'h2AA, LA5 = 11'h34A, LFF = 11'h3FE,
                          L3C = 11'h278, L07 = 11'h20E;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] data = 8'h00;
  logic       tx;
  logic       busy;

  int total = 0;
  int bad   = 0;

  uart_txser #(
    .CLOCKS_PER_BAUD (24'(N)),
    .PARITY_ODD      (PARITY_ODD)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_wr      (wr),
    .i_data    (data),
    .o_uart_tx (tx),
    .o_busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Timeline model: a frame is a list of FB bit values, each held N cycles
  // starting the cycle after the accepting edge.
  int  e_cnt = 0;
  int  ft    = 0;
  bit  act   = 0;
  bit  bits[11];
  bit  exp_tx = 1;
  bit  exp_busy = 0;
  bit  chk_en = 0;

  always @(posedge clk) begin
    int d;
    e_cnt++;
    if (rst) begin
      act = 0;
    end else if (wr && !exp_busy) begin
      act = 1;
      ft  = e_cnt;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = data[i];
`ifdef UART_TX_PARITY_EN
      bits[9]  = (^data) ^ PARITY_ODD;
      bits[10] = 1'b1;
`else
      bits[9]  = 1'b1;
`endif
    end
    d = e_cnt - ft;
    if (act && d >= FB * N) act = 0;
    if (act) begin
      exp_tx   = bits[d / N];
      exp_busy = (d < FB * N - 1);
    end else begin
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
    end
    chk_en = 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_tx", {31'd0, tx}, {31'd0, exp_tx});
      chk("model_busy", {31'd0, busy}, {31'd0, exp_busy});
    end
  end

  // Sends one byte from idle, samples mid-bit, optionally pokes a busy-time
  // write (wr_k) or a reset (rst_k, ends the task right after the reset edge).
  task automatic send_capture(input logic [7:0] b, input logic [10:0] lit,
                              input string nm, input int wr_k, input int rst_k);
    logic [10:0] cap = '0;
    @(negedge clk);
    wr = 1'b1;
    data = b;
    for (int k = 0; k < FB * N; k++) begin
      @(negedge clk);
      if (k == 0) wr = 1'b0;
      if (k == wr_k) begin wr = 1'b1; data = 8'hFF; end
      if (k == wr_k + 1) wr = 1'b0;
      if (k == rst_k) rst = 1'b1;
      if (k == rst_k + 1) begin
        rst = 1'b0;
        chk({nm, "_rst_tx"}, {31'd0, tx}, 32'd1);
        chk({nm, "_rst_busy"}, {31'd0, busy}, 32'd0);
        $display("frame data=%02h abandoned by reset at cycle %0d", b, k);
        return;
      end
      if (k % N == 1) cap[k / N] = tx;
      if (k == 0) chk({nm, "_busy_first"}, {31'd0, busy}, 32'd1);
      if (k == FB * N - 2) chk({nm, "_busy_last"}, {31'd0, busy}, 32'd1);
      if (k == FB * N - 1) chk({nm, "_busy_drop"}, {31'd0, busy}, 32'd0);
    end
    chk({nm, "_bits"}, {21'd0, cap}, {21'd0, lit});
    $display("frame data=%02h line=%03h", b, cap);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    send_capture(8'h55, L55, "single55", -5, -5);
    repeat (3) @(negedge clk);

    send_capture(8'hA5, LA5, "busyignA5", 9, -5);
    repeat (2 * N) @(negedge clk);
    chk("no_second_frame", {31'd0, busy}, 32'd0);

    send_capture(8'h07, L07, "byte07", -5, -5);
    repeat (2) @(negedge clk);

    // Back-to-back with i_wr held high; data changes after the first accept.
    begin
      logic [10:0] cap2 = '0;
      @(negedge clk);
      wr = 1'b1;
      data = 8'h00;
      for (int k = 0; k < 2 * FB * N; k++) begin
        @(negedge clk);
        if (k == 0) data = 8'hFF;
        if (k == FB * N) wr = 1'b0;
        if (k == FB * N - 1) chk("b2b_stop_end", {31'd0, tx}, 32'd1);
        if (k == FB * N) chk("b2b_second_start", {31'd0, tx}, 32'd0);
        if (k == FB * N) chk("b2b_busy", {31'd0, busy}, 32'd1);
        if (k >= FB * N && (k - FB * N) % N == 1) cap2[(k - FB * N) / N] = tx;
      end
      chk("b2b_bits", {21'd0, cap2}, {21'd0, LFF});
      $display("frame data=ff back-to-back line=%03h", cap2);
    end
    repeat (2 * N) @(negedge clk);
    chk("b2b_no_third", {31'd0, busy}, 32'd0);

    send_capture(8'h3C, L3C, "midreset", -5, 14);
    send_capture(8'h3C, L3C, "afterreset", -5, -5);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      wr   = ($urandom_range(0, 3) == 0);
      data = 8'($urandom);
      rst  = ($urandom_range(0, 399) == 0);
      if (wr && !exp_busy && !rst) $display("random write data=%02h cycle=%0d", data, c);
    end
    wr  = 1'b0;
    rst = 1'b0;
    repeat (FB * N + 4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
